conv_encoder: RTL and testbench

Rate-1/2, constraint-length-7 convolutional encoder with generators g0 = 133 octal and g1 = 171 octal. It supports puncturing to rate 2/3 and 3/4 and produces one serial coded bit per clock. It sits directly upstream of the block interleaver and feeds its 1-bit-per-clock serial input. It takes scrambled data bits through a valid/ready handshake and throttles the source so the coded stream never exceeds one bit per cycle.

---
 rtl/conv_encoder.sv | 107 ++++++++++
 tb/tb_conv_encoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder.sv
// rtl/conv_encoder.sv - K=7 rate-1/2 convolutional encoder (g0=133, g1=171) with 2/3 and 3/4 puncturing
// Serialises the kept coded bits one per clock through a two-entry pending buffer.
module conv_encoder #(
  parameter logic [1:0] RATE_DEFAULT = 2'b00
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] Rate,
  input  logic       Input,
  input  logic       Input_Valid,
  output logic       Input_Ready,
  output logic       Output,
  output logic       Output_Valid
);

  logic [5:0] r_delay;   // r_delay[0] = d1 ... r_delay[5] = d6
  logic [1:0] r_rate;
  logic [1:0] r_ph;
  logic [1:0] r_pend;
  logic [1:0] r_n;
  logic       r_out;
  logic       r_out_valid;

  logic       w_xfer;
  logic [1:0] w_rate;
  logic [5:0] w_delay;
  logic [1:0] w_ph;
  logic [1:0] w_ph_next;
  logic       w_a;
  logic       w_b;
  logic       w_keep_a;
  logic       w_keep_b;
  logic       w_ph_last;
  logic [1:0] w_kbits;
  logic [1:0] w_nk;

  assign Input_Ready  = (r_n <= 2'd1);
  assign Output       = r_out;
  assign Output_Valid = r_out_valid;

  always_comb begin
    w_xfer    = Input_Valid & Input_Ready;
    // Start overrides the frame state for a bit transferred in the same cycle
    w_rate    = Start ? Rate : r_rate;
    w_delay   = Start ? 6'd0 : r_delay;
    w_ph      = Start ? 2'd0 : r_ph;
    w_a       = Input ^ w_delay[1] ^ w_delay[2] ^ w_delay[4] ^ w_delay[5];
    w_b       = Input ^ w_delay[0] ^ w_delay[1] ^ w_delay[2] ^ w_delay[5];
    w_keep_a  = 1'b1;
    w_keep_b  = 1'b1;
    w_ph_last = 1'b1;
    case (w_rate)
      2'b01: begin
        w_keep_b  = (w_ph == 2'd0);
        w_ph_last = (w_ph == 2'd1);
      end
      2'b10: begin
        w_keep_a  = (w_ph != 2'd2);
        w_keep_b  = (w_ph != 2'd1);
        w_ph_last = (w_ph == 2'd2);
      end
      default: begin
        w_keep_a  = 1'b1;
        w_keep_b  = 1'b1;
        w_ph_last = 1'b1;
      end
    endcase
    w_ph_next = w_ph_last ? 2'd0 : w_ph + 2'd1;
    w_kbits   = w_keep_a ? {w_b, w_a} : {1'b0, w_b};
    w_nk      = {1'b0, w_keep_a} + {1'b0, w_keep_b};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_delay     <= 6'd0;
      r_rate      <= RATE_DEFAULT;
      r_ph        <= 2'd0;
      r_pend      <= 2'd0;
      r_n         <= 2'd0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out       <= (r_n != 2'd0) ? r_pend[0] : 1'b0;
      r_out_valid <= (r_n != 2'd0);
      // A transfer needs N<=1, so after this edge's emit nothing older remains
      if (w_xfer) begin
        r_pend <= w_kbits;
        r_n    <= w_nk;
      end else if (r_n != 2'd0) begin
        r_pend <= {1'b0, r_pend[1]};
        r_n    <= r_n - 2'd1;
      end
      if (Start) begin
        r_rate <= Rate;
      end
      if (w_xfer) begin
        r_delay <= {w_delay[4:0], Input};
        r_ph    <= w_ph_next;
      end else if (Start) begin
        r_delay <= 6'd0;
        r_ph    <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// tb/tb_conv_encoder.sv - self-checking bench for conv_encoder
// Reference model works from the generator polynomials and puncture tables.
module tb_conv_encoder;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [1:0] Rate = 2'b00;
  logic       Input = 1'b0;
  logic       Input_Valid = 1'b0;
  logic       Input_Ready;
  logic       Output;
  logic       Output_Valid;

  int tests = 0;
  int fails = 0;

  logic exp_q[$];
  logic got[$];
  int   m_st, m_rate, m_ph;
  logic cont = 1'b0;
  int   last_wait;

  conv_encoder #(.RATE_DEFAULT(2'b00)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Rate(Rate),
    .Input(Input), .Input_Valid(Input_Valid), .Input_Ready(Input_Ready),
    .Output(Output), .Output_Valid(Output_Valid)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] keep_mask(input int rate, input int ph);
    // bit1: A kept, bit0: B kept
    if (rate == 1) return (ph == 0) ? 2'b11 : 2'b10;
    if (rate == 2) return (ph == 0) ? 2'b11 : (ph == 1) ? 2'b10 : 2'b01;
    return 2'b11;
  endfunction

  task automatic m_start(input logic [1:0] r);
    m_st   = 0;
    m_ph   = 0;
    m_rate = (r == 2'b11) ? 0 : int'(r);
  endtask

  task automatic m_push(input logic b);
    int win;
    logic a, bb;
    logic [1:0] mk;
    win = (int'(b) << 6) | m_st;
    a   = 1'($countones(win & 'o133) & 1);
    bb  = 1'($countones(win & 'o171) & 1);
    m_st = win >> 1;
    mk = keep_mask(m_rate, m_ph);
    if (mk[1]) exp_q.push_back(a);
    if (mk[0]) exp_q.push_back(bb);
    m_ph = (m_ph + 1) % (m_rate + 1);
  endtask

  task automatic step(input logic v, input logic b, input logic st, input logic [1:0] r);
    logic acc;
    Input_Valid = v;
    Input       = b;
    Start       = st;
    Rate        = r;
    #1;
    acc = v && Input_Ready;
    if (st) m_start(r);
    if (acc) m_push(b);
    @(posedge Clock);
    #1;
    Start       = 1'b0;
    Input_Valid = 1'b0;
    if (Output_Valid === 1'b1) begin
      got.push_back(Output);
      chk_i("exp_avail", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("stream_bit", Output, exp_q.pop_front());
    end
    if (cont) chk("ov_continuous", Output_Valid, 1'b1);
    @(negedge Clock);
  endtask

  task automatic send(input logic b, input logic st, input logic [1:0] r);
    int w;
    logic done;
    w = 0;
    done = 1'b0;
    while (!done && w < 10) begin
      if (Input_Ready) begin
        step(1'b1, b, st, r);
        done = 1'b1;
      end else begin
        step(1'b1, b, 1'b0, r);
        w++;
      end
    end
    chk("send_accepted", done, 1'b1);
    last_wait = w;
  endtask

  task automatic drain();
    int k;
    cont = 1'b0;
    k = 0;
    step(1'b0, 1'b0, 1'b0, 2'b00);
    while (Output_Valid === 1'b1 && k < 8) begin
      step(1'b0, 1'b0, 1'b0, 2'b00);
      k++;
    end
    chk("drain_ov_low", Output_Valid, 1'b0);
    chk("drain_ready", Input_Ready, 1'b1);
    chk_i("drain_exp_empty", exp_q.size(), 0);
  endtask

  task automatic impulse(input logic st, input logic [1:0] r, input int nbits,
                         input logic [15:0] expv, input int len, input logic toggle);
    got.delete();
    send(1'b1, st, r);
    cont = 1'b1;
    for (int i = 1; i < nbits; i++) begin
      send(1'b0, 1'b0, 2'b00);
      if (toggle) chk_i("ready_toggle_wait", last_wait, 1);
    end
    drain();
    chk_i("impulse_len", got.size(), len);
    for (int i = 0; i < len && i < got.size(); i++)
      chk("impulse_bit", got[i], expv[len-1-i]);
  endtask

  initial begin
    logic [1:0] rr;
    logic       rb;
    m_start(2'b00);
    #12;
    chk("reset_output", Output, 1'b0);
    chk("reset_ov", Output_Valid, 1'b0);
    chk("reset_ready", Input_Ready, 1'b1);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);

    impulse(1'b1, 2'b00, 7, 16'b11011111001011, 14, 1'b1);
    impulse(1'b1, 2'b10, 6, 16'b11011100, 8, 1'b0);
    impulse(1'b1, 2'b01, 4, 16'b110111, 6, 1'b0);
    impulse(1'b1, 2'b11, 7, 16'b11011111001011, 14, 1'b1);

    // Start mid-stream together with a transfer of bit 1
    got.delete();
    send(1'($urandom_range(0, 1)), 1'b1, 2'b00);
    for (int i = 0; i < 4; i++) send(1'($urandom_range(0, 1)), 1'b0, 2'b00);
    send(1'b1, 1'b1, 2'b00);
    drain();
    chk_i("midstart_len", got.size(), 12);
    if (got.size() >= 12) begin
      chk("midstart_a", got[10], 1'b1);
      chk("midstart_b", got[11], 1'b1);
    end

    // Randomised frames at all four rate codes, with input gaps
    for (int f = 0; f < 6; f++) begin
      rr = 2'($urandom_range(0, 3));
      send(1'($urandom_range(0, 1)), 1'b1, rr);
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0, 2'b00);
        rb = 1'($urandom_range(0, 1));
        send(rb, 1'b0, 2'b00);
      end
    end
    drain();

    // Async reset while two bits are pending
    send(1'b1, 1'b1, 2'b00);
    chk("prereset_not_ready", Input_Ready, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_ov", Output_Valid, 1'b0);
    chk("async_ready", Input_Ready, 1'b1);
    chk("async_output", Output, 1'b0);
    #1;
    Reset = 1'b0;
    exp_q.delete();
    m_start(2'b00);
    @(negedge Clock);
    impulse(1'b0, 2'b00, 7, 16'b11011111001011, 14, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
